// File: rtl/frame_config_writer_if.sv
// Config word stream into the frame writer: 32-bit word with valid/ready handshake.
interface frame_config_writer_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_config_writer.sv
// Assembles one config frame (header, then one word per tile row) and pulses one FrameStrobe bit; FRAME_PARITY_EN adds an XOR trailer.
// Latency: strobe rises 2 cycles after the last data word (or trailer) is accepted and is held for StrobeCycles.
// Backpressure: s_ready is low in COMMIT/STROBE; s_valid low during a frame stalls indefinitely.
module frame_config_writer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 16,
    parameter int NumColumns      = 16,
    parameter int StrobeCycles    = 2
) (
    input  logic                                   UserCLK,
    input  logic                                   Reset,
    frame_config_writer_if.slave                   s_if,
    output logic [FrameBitsPerRow*NumRows-1:0]     FrameData,
    output logic [MaxFramesPerCol*NumColumns-1:0]  FrameStrobe,
    output logic                                   busy,
    output logic                                   error
);

    localparam int ROW_W   = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int CNT_W   = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam int NSTROBE = MaxFramesPerCol * NumColumns;

    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(NumRows - 1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(StrobeCycles - 1);
    localparam logic [7:0]       NUM_COLS_B   = 8'(NumColumns);
    localparam logic [7:0]       NUM_FRAMES_B = 8'(MaxFramesPerCol);

`ifdef FRAME_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_COMMIT, ST_STROBE} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_COMMIT, ST_STROBE} state_t;
`endif

    state_t state_q, state_d;

    logic [ROW_W-1:0]                           row_q, row_d;
    logic [7:0]                                 col_q, col_d;
    logic [7:0]                                 frame_q, frame_d;
    logic                                       bad_q, bad_d;
    logic                                       error_q, error_d;
    logic [CNT_W-1:0]                           cnt_q, cnt_d;
    logic [NumRows-1:0][FrameBitsPerRow-1:0]    data_q, data_d;
    logic [NSTROBE-1:0]                         strobe_q, strobe_d;
`ifdef FRAME_PARITY_EN
    logic [31:0]                                parity_q, parity_d;
`endif

    logic        s_ready;
    logic        accept;
    logic        is_header;
    logic [15:0] strobe_idx;

    assign accept     = s_if.s_valid & s_ready;
    assign is_header  = s_if.s_data[31];
    assign strobe_idx = 16'(col_q) * 16'(MaxFramesPerCol) + 16'(frame_q);

    // State register
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && is_header) state_d = ST_LOAD;
            ST_LOAD: begin
                if (accept && row_q == ROW_LAST) begin
`ifdef FRAME_PARITY_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_COMMIT;
`endif
                end
            end
`ifdef FRAME_PARITY_EN
            ST_CHECK:  if (accept) state_d = ST_COMMIT;
`endif
            ST_COMMIT: state_d = bad_q ? ST_IDLE : ST_STROBE;
            ST_STROBE: if (cnt_q == CNT_LAST) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready = 1'b0;
        busy    = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE:  s_ready = 1'b1;
            ST_LOAD:  s_ready = 1'b1;
`ifdef FRAME_PARITY_EN
            ST_CHECK: s_ready = 1'b1;
`endif
            default:  s_ready = 1'b0;
        endcase
    end

    // Datapath next values
    always_comb begin
        row_d    = row_q;
        col_d    = col_q;
        frame_d  = frame_q;
        bad_d    = bad_q;
        error_d  = error_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        strobe_d = '0;
`ifdef FRAME_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept && is_header) begin
                    col_d   = s_if.s_data[23:16];
                    frame_d = s_if.s_data[7:0];
                    bad_d   = (s_if.s_data[23:16] >= NUM_COLS_B) |
                              (s_if.s_data[7:0]   >= NUM_FRAMES_B);
                    row_d   = '0;
`ifdef FRAME_PARITY_EN
                    parity_d = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    data_d[row_q] = s_if.s_data;
                    row_d         = row_q + 1'b1;
`ifdef FRAME_PARITY_EN
                    parity_d      = parity_q ^ s_if.s_data;
`endif
                end
            end
`ifdef FRAME_PARITY_EN
            ST_CHECK: begin
                if (accept && s_if.s_data != parity_q) bad_d = 1'b1;
            end
`endif
            ST_COMMIT: begin
                cnt_d = '0;
                if (bad_q) begin
                    error_d = 1'b1;
                end else begin
                    strobe_d = NSTROBE'(1) << strobe_idx;
                end
            end
            ST_STROBE: begin
                // Hold the one-hot strobe until the final high cycle, then release it.
                if (cnt_q != CNT_LAST) begin
                    strobe_d = strobe_q;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            row_q    <= '0;
            col_q    <= '0;
            frame_q  <= '0;
            bad_q    <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            strobe_q <= '0;
`ifdef FRAME_PARITY_EN
            parity_q <= '0;
`endif
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            frame_q  <= frame_d;
            bad_q    <= bad_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
`ifdef FRAME_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign s_if.s_ready = s_ready;
    assign FrameData    = data_q;
    assign FrameStrobe  = strobe_q;
    assign error        = error_q;

endmodule

// File: tb/tb_frame_config_writer.sv
// Scoreboard bench: frame stimulus pushes expected strobe index/data/latency/duration; a monitor checks each strobe.
module tb_frame_config_writer;

    logic         clk;
    logic         Reset;
    logic [511:0] FrameData;
    logic [319:0] FrameStrobe;
    logic         busy;
    logic         error;

    frame_config_writer_if ifc();

    frame_config_writer dut (
        .UserCLK     (clk),
        .Reset       (Reset),
        .s_if        (ifc),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [511:0] data;
        int           acc;
        int           dur;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        ifc.s_valid = 1'b1;
        ifc.s_data  = w;
        while (!ifc.s_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("send_timeout", 512'(0), 512'(1));
        @(posedge clk);
        last_acc = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        ifc.s_valid = 1'b0;
    endtask

    // exp_idx < 0 marks a frame that must never strobe.
    task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base, input bit gap,
                              input bit corrupt, input int exp_idx, input int dur);
        exp_t         e;
        logic [31:0]  w;
        logic [31:0]  par;
        par = '0;
        e.data = '0;
        send(hdr);
        for (int r = 0; r < 16; r++) begin
            w = base + 32'(r);
            e.data[r*32 +: 32] = w;
            par = par ^ w;
            send(w);
            if (gap) idle();
        end
`ifdef FRAME_PARITY_EN
        send(corrupt ? (par ^ 32'h1) : par);
`else
        if (corrupt) par = ~par;
`endif
        if (exp_idx >= 0) begin
            e.idx = exp_idx;
            e.acc = last_acc;
            e.dur = dur;
            q.push_back(e);
        end
        idle();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 512'(0), 512'(1));
    endtask

    // Monitor
    exp_t         cur;
    bit           cur_vld = 0;
    bit           strobe_prev = 0;
    int           hi_cnt = 0;
    logic [511:0] held_data;

    always @(negedge clk) begin
        if (FrameStrobe != '0 && !strobe_prev) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 512'(FrameStrobe), 512'(0));
                cur_vld = 0;
            end else begin
                cur = q.pop_front();
                cur_vld = 1;
                chk("strobe_bit", 512'(FrameStrobe), 512'(320'(1) << cur.idx));
                chk("frame_data", FrameData, cur.data);
                chk("strobe_latency", 512'(cyc - cur.acc), 512'(2));
            end
            hi_cnt = 1;
            held_data = FrameData;
        end else if (FrameStrobe != '0) begin
            hi_cnt++;
            chk("strobe_hold", 512'(FrameStrobe), 512'(320'(1) << cur.idx));
            chk("data_stable", FrameData, held_data);
        end else if (strobe_prev && cur_vld) begin
            chk("strobe_cycles", 512'(hi_cnt), 512'(cur.dur));
            chk("ready_after_strobe", 512'(ifc.s_ready), 512'(1));
            chk("busy_after_strobe", 512'(busy), 512'(0));
        end
        strobe_prev = (FrameStrobe != '0);
    end

    initial begin
        int n;
        Reset = 1'b1;
        ifc.s_valid = 1'b0;
        ifc.s_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_strobe", 512'(FrameStrobe), 512'(0));
        chk("rst_data", FrameData, 512'(0));
        chk("rst_error", 512'(error), 512'(0));
        chk("rst_ready", 512'(ifc.s_ready), 512'(1));
        chk("rst_busy", 512'(busy), 512'(0));
        Reset = 1'b0;

        // Basic frame: col 3 frame 5 -> bit 65
        send_frame(32'h8003_0005, 32'h1000_0000, 0, 0, 65, 2);
        wait_idle();
        chk("t1_error", 512'(error), 512'(0));

        // Frame index 20 out of range, then column 16 out of range
        send_frame(32'h8000_0014, 32'h4000_0000, 0, 0, -1, 2);
        wait_idle();
        chk("bad_frame_error", 512'(error), 512'(1));
        send_frame(32'h8010_0000, 32'h5000_0000, 0, 0, -1, 2);
        wait_idle();
        chk("bad_col_error", 512'(error), 512'(1));
        send_frame(32'h8000_0000, 32'h2000_0000, 0, 0, 0, 2);

        // Non-header words in IDLE are dropped
        send(32'h1234_5678);
        send(32'h0000_0000);
        idle();
        chk("drop_busy", 512'(busy), 512'(0));
        send_frame(32'h800F_0013, 32'hA5A5_0000, 0, 0, 319, 2);

        // s_valid toggled during LOAD
        send_frame(32'h8003_0005, 32'h1000_0000, 1, 0, 65, 2);

`ifdef FRAME_PARITY_EN
        send_frame(32'h8004_0001, 32'h0F0F_0000, 0, 0, 81, 2);
        send_frame(32'h8004_0002, 32'h0F0F_0000, 0, 1, -1, 2);
        wait_idle();
        chk("parity_error", 512'(error), 512'(1));
`endif

        // Reset in the first strobe cycle: col 1 frame 2 -> bit 22
        send_frame(32'h8001_0002, 32'h3000_0000, 0, 0, 22, 1);
        n = 0;
        while (FrameStrobe == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("strobe_timeout", 512'(0), 512'(1));
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_strobe", 512'(FrameStrobe), 512'(0));
        chk("mid_rst_data", FrameData, 512'(0));
        chk("mid_rst_error", 512'(error), 512'(0));
        chk("mid_rst_ready", 512'(ifc.s_ready), 512'(1));
        Reset = 1'b0;

        send_frame(32'h8002_0000, 32'h6000_0000, 0, 0, 40, 2);
        n = 0;
        while ((q.size() != 0 || busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pending_strobes", 512'(q.size()), 512'(0));
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
